// File: rtl/wb_stage_nlane_if.sv
// Memory-stage to writeback-stage bundle handshake for wb_stage_nlane.
// The memory stage is the master; the writeback stage is the slave.
interface wb_stage_nlane_if #(
  parameter int LANES = 2
);
  logic                  ws_allowin;
  logic                  ms_to_ws_valid;
  logic [LANES-1:0]      ms_lane_valid;
  logic [LANES-1:0]      ms_lane_we;
  logic [5*LANES-1:0]    ms_lane_dest;
  logic [32*LANES-1:0]   ms_lane_result;
  logic [32*LANES-1:0]   ms_lane_pc;

  modport master (
    input  ws_allowin,
    output ms_to_ws_valid, ms_lane_valid, ms_lane_we,
    output ms_lane_dest, ms_lane_result, ms_lane_pc
  );

  modport slave (
    output ws_allowin,
    input  ms_to_ws_valid, ms_lane_valid, ms_lane_we,
    input  ms_lane_dest, ms_lane_result, ms_lane_pc
  );
endinterface

// File: rtl/wb_stage_nlane.sv
// N-lane writeback stage: resolves same-destination collisions, serialises RF writes
// onto RF_WPORTS ports and the debug trace to one retirement per cycle (macro WB_TRACE_EN).
module wb_stage_nlane #(
  parameter int LANES     = 2,
  parameter int RF_WPORTS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  wb_stage_nlane_if.slave         ms,
  output logic [RF_WPORTS-1:0]    rf_we,
  output logic [5*RF_WPORTS-1:0]  rf_waddr,
  output logic [32*RF_WPORTS-1:0] rf_wdata,
  output logic [LANES-1:0]        fwd_valid,
  output logic [5*LANES-1:0]      fwd_dest,
  output logic [32*LANES-1:0]     fwd_data,
  output logic [31:0]             debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [31:0]             debug_wb_rf_wdata
);

  function automatic logic [LANES-1:0] arch_writes(
    input logic [LANES-1:0]      valid,
    input logic [LANES-1:0]      we,
    input logic [LANES-1:0][4:0] dest
  );
    logic [LANES-1:0] wr;
    for (int i = 0; i < LANES; i++) wr[i] = valid[i] & we[i] & (dest[i] != 5'd0);
    return wr;
  endfunction

  // Only the youngest writer of each destination survives to the register file.
  function automatic logic [LANES-1:0] youngest_writers(
    input logic [LANES-1:0]      wr,
    input logic [LANES-1:0][4:0] dest
  );
    logic [LANES-1:0] keep;
    keep = wr;
    for (int i = 0; i < LANES; i++)
      for (int j = i + 1; j < LANES; j++)
        if (wr[i] && wr[j] && dest[i] == dest[j]) keep[i] = 1'b0;
    return keep;
  endfunction

  logic                        ws_valid;
  logic                        ws_allowin;
  logic                        ws_ready_go;
  logic                        accept;
  logic                        rf_done;
  logic                        tr_done;

  logic [LANES-1:0]            lane_valid;
  logic [LANES-1:0]            lane_we;
  logic [LANES-1:0][4:0]       lane_dest;
  logic [LANES-1:0][31:0]      lane_result;

  logic [LANES-1:0][4:0]       in_dest;
  logic [LANES-1:0]            in_arch;
  logic [LANES-1:0]            in_rf_set;
  logic [LANES-1:0]            arch_wr;
  logic [LANES-1:0]            rf_set;
  logic [LANES-1:0]            rf_pend;
  logic [LANES-1:0]            rf_issued;

  logic [RF_WPORTS-1:0][4:0]   port_addr;
  logic [RF_WPORTS-1:0][31:0]  port_data;

  assign in_dest   = ms.ms_lane_dest;
  assign in_arch   = arch_writes(ms.ms_lane_valid, ms.ms_lane_we, in_dest);
  assign in_rf_set = youngest_writers(in_arch, in_dest);

  assign arch_wr   = ws_valid ? arch_writes(lane_valid, lane_we, lane_dest) : '0;
  assign rf_set    = youngest_writers(arch_wr, lane_dest);

  assign rf_done       = ($countones(rf_pend) <= RF_WPORTS);
  assign ws_ready_go   = rf_done & tr_done;
  assign ws_allowin    = !ws_valid | ws_ready_go;
  assign ms.ws_allowin = ws_allowin;
  assign accept        = ms.ms_to_ws_valid & ws_allowin;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    int rank;
    rf_we     = '0;
    port_addr = '0;
    port_data = '0;
    rf_issued = '0;
    rank      = 0;
    for (int i = 0; i < LANES; i++) begin
      if (rf_pend[i]) begin
        for (int p = 0; p < RF_WPORTS; p++) begin
          if (rank == p) begin
            rf_we[p]     = 1'b1;
            port_addr[p] = lane_dest[i];
            port_data[p] = lane_result[i];
            rf_issued[i] = 1'b1;
          end
        end
        rank = rank + 1;
      end
    end
  end

  assign rf_waddr = port_addr;
  assign rf_wdata = port_data;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid <= 1'b0;
      rf_pend  <= '0;
    end else if (accept) begin
      ws_valid <= 1'b1;
      rf_pend  <= in_rf_set;
    end else if (ws_ready_go) begin
      ws_valid <= 1'b0;
      rf_pend  <= '0;
    end else begin
      rf_pend  <= rf_pend & ~rf_issued;
    end
  end

  // NOTE: lane payload is not reset; it is only observed while qualified by
  // ws_valid or the pending masks, which are reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lane_valid  <= ms.ms_lane_valid;
      lane_we     <= ms.ms_lane_we;
      lane_dest   <= in_dest;
      lane_result <= ms.ms_lane_result;
    end
  end

  assign fwd_valid = rf_set;
  assign fwd_dest  = lane_dest;
  assign fwd_data  = lane_result;

`ifdef WB_TRACE_EN
  logic [LANES-1:0]       tr_pend;
  logic [LANES-1:0]       tr_sel;
  logic [LANES-1:0][31:0] lane_pc;

  // One-hot of the oldest lane still waiting to be traced.
  assign tr_sel  = tr_pend & (~tr_pend + LANES'(1));
  assign tr_done = ($countones(tr_pend) <= 1);

  always_ff @(posedge clk) begin
    if (reset)            tr_pend <= '0;
    else if (accept)      tr_pend <= in_arch;
    else if (ws_ready_go) tr_pend <= '0;
    else                  tr_pend <= tr_pend & ~tr_sel;
  end

  always_ff @(posedge clk) begin
    if (accept) lane_pc <= ms.ms_lane_pc;
  end

  always_comb begin
    debug_wb_rf_wen   = 4'h0;
    debug_wb_pc       = lane_pc[0];
    debug_wb_rf_wnum  = 5'd0;
    debug_wb_rf_wdata = 32'd0;
    for (int i = 0; i < LANES; i++) begin
      if (tr_sel[i]) begin
        debug_wb_rf_wen   = 4'hf;
        debug_wb_pc       = lane_pc[i];
        debug_wb_rf_wnum  = lane_dest[i];
        debug_wb_rf_wdata = lane_result[i];
      end
    end
  end
`else
  logic unused_pc;

  // Without tracing the PCs have no consumer.
  assign unused_pc         = ^ms.ms_lane_pc;
  assign tr_done           = 1'b1;
  assign debug_wb_pc       = 32'd0;
  assign debug_wb_rf_wen   = 4'h0;
  assign debug_wb_rf_wnum  = 5'd0;
  assign debug_wb_rf_wdata = 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage_nlane.sv
// Self-checking bench for wb_stage_nlane (LANES=4, RF_WPORTS=2): directed vector
// table, hand-written reset/back-to-back sequences and a random run against a queue model.
module tb_wb_stage_nlane;

  localparam int LANES = 4;
  localparam int NP    = 2;
`ifdef WB_TRACE_EN
  localparam bit TRACE = 1'b1;
`else
  localparam bit TRACE = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]       v;
    logic [3:0]       we;
    logic [3:0][4:0]  d;
    logic [3:0][31:0] r;
    logic [3:0][31:0] p;
  } bundle_t;

  typedef struct {
    bundle_t     b;
    int          cyc_tr;
    int          cyc_nt;
    logic [1:0]  we0;
    logic [9:0]  addr0;
    logic [3:0]  fwd;
  } vec_t;

  typedef struct packed { logic [4:0] a; logic [31:0] d; } rfw_t;
  typedef struct packed { logic [31:0] pc; logic [4:0] n; logic [31:0] d; } trw_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_stage_nlane_if #(.LANES(LANES)) ms_if ();

  logic [NP-1:0]     rf_we;
  logic [5*NP-1:0]   rf_waddr;
  logic [32*NP-1:0]  rf_wdata;
  logic [LANES-1:0]  fwd_valid;
  logic [5*LANES-1:0]  fwd_dest;
  logic [32*LANES-1:0] fwd_data;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  wb_stage_nlane #(.LANES(LANES), .RF_WPORTS(NP)) dut (
    .clk               (clk),
    .reset             (reset),
    .ms                (ms_if),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .fwd_valid         (fwd_valid),
    .fwd_dest          (fwd_dest),
    .fwd_data          (fwd_data),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the resident bundle as lists of outstanding RF writes and trace events.
  bit               m_valid = 1'b0;
  bit               have_pc = 1'b0;
  rfw_t             rfq[$];
  trw_t             trq[$];
  logic [3:0]       m_fwd;
  logic [3:0][4:0]  m_dest;
  logic [3:0][31:0] m_res;
  logic [31:0]      m_pc0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bundle_t mkb(input logic [3:0] v, input logic [3:0] we,
                                  input logic [4:0] d0, input logic [4:0] d1,
                                  input logic [4:0] d2, input logic [4:0] d3,
                                  input logic [31:0] r0, input logic [31:0] r1,
                                  input logic [31:0] r2, input logic [31:0] r3);
    bundle_t b;
    b.v = v; b.we = we;
    b.d[0] = d0; b.d[1] = d1; b.d[2] = d2; b.d[3] = d3;
    b.r[0] = r0; b.r[1] = r1; b.r[2] = r2; b.r[3] = r3;
    for (int i = 0; i < LANES; i++) b.p[i] = 32'h1000_0040 + 32'(i * 4);
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    for (int i = 0; i < LANES; i++) begin
      b.v[i]  = ($urandom_range(0, 7) != 0);
      b.we[i] = ($urandom_range(0, 3) != 0);
      b.d[i]  = 5'($urandom_range(0, 5));
      b.r[i]  = $urandom;
      b.p[i]  = $urandom & 32'hffff_fffc;
    end
    return b;
  endfunction

  function automatic bit model_allowin();
    return !m_valid || (rfq.size() <= NP && (!TRACE || trq.size() <= 1));
  endfunction

  task automatic model_load(input bundle_t b);
    bit wr[LANES];
    bit younger;
    m_valid = 1'b1; have_pc = 1'b1;
    m_dest = b.d; m_res = b.r; m_pc0 = b.p[0]; m_fwd = '0;
    rfq.delete(); trq.delete();
    for (int i = 0; i < LANES; i++) wr[i] = b.v[i] && b.we[i] && (b.d[i] != 5'd0);
    for (int i = 0; i < LANES; i++) begin
      if (wr[i]) begin
        trq.push_back('{pc: b.p[i], n: b.d[i], d: b.r[i]});
        younger = 1'b0;
        for (int j = i + 1; j < LANES; j++) if (wr[j] && b.d[j] == b.d[i]) younger = 1'b1;
        if (!younger) begin
          rfq.push_back('{a: b.d[i], d: b.r[i]});
          m_fwd[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_edge(input bit rst, input bit acc, input bundle_t b);
    bit done;
    if (rst) begin
      m_valid = 1'b0; rfq.delete(); trq.delete();
      return;
    end
    if (m_valid) begin
      done = model_allowin();
      for (int k = 0; k < NP; k++) if (rfq.size() > 0) void'(rfq.pop_front());
      if (TRACE && trq.size() > 0) void'(trq.pop_front());
      if (done) m_valid = 1'b0;
    end
    if (acc) model_load(b);
  endtask

  task automatic model_check();
    logic [NP-1:0]       e_we;
    logic [NP-1:0][4:0]  e_addr;
    logic [NP-1:0][31:0] e_data;
    e_we = '0; e_addr = '0; e_data = '0;
    for (int p = 0; p < NP; p++) begin
      if (p < rfq.size()) begin
        e_we[p] = 1'b1; e_addr[p] = rfq[p].a; e_data[p] = rfq[p].d;
      end
    end
    check("ws_allowin", 128'(ms_if.ws_allowin), 128'(model_allowin()));
    check("rf_we", 128'(rf_we), 128'(e_we));
    check("rf_waddr", 128'(rf_waddr), 128'(e_addr));
    check("rf_wdata", 128'(rf_wdata), 128'(e_data));
    check("fwd_valid", 128'(fwd_valid), 128'(m_valid ? m_fwd : 4'h0));
    if (m_valid) begin
      check("fwd_dest", 128'(fwd_dest), 128'(m_dest));
      check("fwd_data", 128'(fwd_data), 128'(m_res));
    end
    if (TRACE && trq.size() > 0) begin
      check("dbg_wen", 128'(debug_wb_rf_wen), 128'(4'hf));
      check("dbg_pc", 128'(debug_wb_pc), 128'(trq[0].pc));
      check("dbg_wnum", 128'(debug_wb_rf_wnum), 128'(trq[0].n));
      check("dbg_wdata", 128'(debug_wb_rf_wdata), 128'(trq[0].d));
    end else begin
      check("dbg_wen", 128'(debug_wb_rf_wen), 128'(4'h0));
      check("dbg_wnum", 128'(debug_wb_rf_wnum), 128'(5'd0));
      check("dbg_wdata", 128'(debug_wb_rf_wdata), 128'(32'd0));
      if (!TRACE) check("dbg_pc", 128'(debug_wb_pc), 128'(32'd0));
      else if (have_pc) check("dbg_pc", 128'(debug_wb_pc), 128'(m_pc0));
    end
  endtask

  // One clock: present inputs at the negedge, check, advance the model at posedge.
  task automatic cycle(input bit offer, input bundle_t b);
    bit exp_a;
    ms_if.ms_to_ws_valid = offer;
    ms_if.ms_lane_valid  = b.v;
    ms_if.ms_lane_we     = b.we;
    ms_if.ms_lane_dest   = b.d;
    ms_if.ms_lane_result = b.r;
    ms_if.ms_lane_pc     = b.p;
    #1;
    model_check();
    exp_a = model_allowin();
    @(posedge clk);
    model_edge(reset, offer && exp_a && !reset, b);
    @(negedge clk);
  endtask

  vec_t    vecs[10];
  bundle_t idle_b;
  bundle_t ba, bb, rb;
  int      c;
  int      occ_a;

  initial begin
    idle_b = '0;
    vecs[0] = '{mkb(4'b0011, 4'b0011, 5'd3, 5'd4, 5'd0, 5'd0, 32'h11, 32'h22, 32'h0, 32'h0),
                2, 1, 2'b11, {5'd4, 5'd3}, 4'b0011};
    vecs[1] = '{mkb(4'b0011, 4'b0011, 5'd5, 5'd5, 5'd0, 5'd0, 32'hA, 32'hB, 32'h0, 32'h0),
                2, 1, 2'b01, {5'd0, 5'd5}, 4'b0010};
    vecs[2] = '{mkb(4'b1111, 4'b1111, 5'd1, 5'd2, 5'd3, 5'd4, 32'h101, 32'h102, 32'h103, 32'h104),
                4, 2, 2'b11, {5'd2, 5'd1}, 4'b1111};
    vecs[3] = '{mkb(4'b1101, 4'b1111, 5'd7, 5'd9, 5'd0, 5'd8, 32'h1, 32'h99, 32'h77, 32'h2),
                2, 1, 2'b11, {5'd8, 5'd7}, 4'b1001};
    vecs[4] = '{mkb(4'b1111, 4'b0000, 5'd1, 5'd2, 5'd3, 5'd4, 32'h5, 32'h6, 32'h7, 32'h8),
                1, 1, 2'b00, 10'd0, 4'b0000};
    vecs[5] = '{mkb(4'b1111, 4'b1111, 5'd0, 5'd0, 5'd0, 5'd0, 32'h5, 32'h6, 32'h7, 32'h8),
                1, 1, 2'b00, 10'd0, 4'b0000};
    vecs[6] = '{mkb(4'b1111, 4'b1111, 5'd9, 5'd9, 5'd9, 5'd10, 32'h91, 32'h92, 32'h93, 32'hA0),
                4, 1, 2'b11, {5'd10, 5'd9}, 4'b1100};
    vecs[7] = '{mkb(4'b0000, 4'b1111, 5'd1, 5'd2, 5'd3, 5'd4, 32'h5, 32'h6, 32'h7, 32'h8),
                1, 1, 2'b00, 10'd0, 4'b0000};
    vecs[8] = '{mkb(4'b1111, 4'b1111, 5'd7, 5'd6, 5'd7, 5'd6, 32'h71, 32'h61, 32'h72, 32'h62),
                4, 1, 2'b11, {5'd6, 5'd7}, 4'b1100};
    vecs[9] = '{mkb(4'b0111, 4'b0111, 5'd1, 5'd2, 5'd3, 5'd0, 32'h31, 32'h32, 32'h33, 32'h0),
                3, 2, 2'b11, {5'd2, 5'd1}, 4'b0111};

    reset = 1'b1;
    ms_if.ms_to_ws_valid = 1'b0;
    ms_if.ms_lane_valid  = '0;
    ms_if.ms_lane_we     = '0;
    ms_if.ms_lane_dest   = '0;
    ms_if.ms_lane_result = '0;
    ms_if.ms_lane_pc     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ws_allowin", 128'(ms_if.ws_allowin), 128'(1'b1));
    check("reset rf_we", 128'(rf_we), 128'(2'b00));
    check("reset fwd_valid", 128'(fwd_valid), 128'(4'h0));
    check("reset dbg_wen", 128'(debug_wb_rf_wen), 128'(4'h0));
    reset = 1'b0;

    // Directed vectors: first-cycle port usage, forwarding mask and occupancy.
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, idle_b);
      cycle(1'b1, vecs[k].b);
      check($sformatf("vec%0d rf_we", k), 128'(rf_we), 128'(vecs[k].we0));
      check($sformatf("vec%0d rf_waddr", k), 128'(rf_waddr), 128'(vecs[k].addr0));
      check($sformatf("vec%0d fwd_valid", k), 128'(fwd_valid), 128'(vecs[k].fwd));
      c = 1;
      while (!ms_if.ws_allowin && c < 20) begin
        cycle(1'b0, idle_b);
        c++;
      end
      check($sformatf("vec%0d occupancy", k), 128'(c),
            128'(TRACE ? vecs[k].cyc_tr : vecs[k].cyc_nt));
    end

    // Writeless bundle: trace stays idle and shows lane 0 PC when tracing.
    cycle(1'b0, idle_b);
    cycle(1'b1, vecs[4].b);
    check("empty dbg_wen", 128'(debug_wb_rf_wen), 128'(4'h0));
    check("empty dbg_pc", 128'(debug_wb_pc), 128'(TRACE ? vecs[4].b.p[0] : 32'd0));
    check("empty allowin", 128'(ms_if.ws_allowin), 128'(1'b1));

    // Reset in the second cycle of a multi-cycle bundle abandons remaining writes.
    cycle(1'b0, idle_b);
    cycle(1'b1, vecs[2].b);
    cycle(1'b0, idle_b);
    reset = 1'b1;
    cycle(1'b0, idle_b);
    reset = 1'b0;
    check("rst_mid rf_we", 128'(rf_we), 128'(2'b00));
    check("rst_mid allowin", 128'(ms_if.ws_allowin), 128'(1'b1));
    check("rst_mid dbg_wen", 128'(debug_wb_rf_wen), 128'(4'h0));
    check("rst_mid fwd_valid", 128'(fwd_valid), 128'(4'h0));
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, idle_b);
      check("rst_mid quiet rf_we", 128'(rf_we), 128'(2'b00));
    end

    // Back-to-back: the next bundle is taken on the completing edge, no bubble.
    ba = vecs[2].b;
    bb = mkb(4'b1111, 4'b1111, 5'd11, 5'd12, 5'd13, 5'd14, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
    occ_a = TRACE ? 4 : 2;
    cycle(1'b1, ba);
    repeat (occ_a) cycle(1'b1, bb);
    check("b2b rf_we", 128'(rf_we), 128'(2'b11));
    check("b2b rf_waddr", 128'(rf_waddr), 128'({5'd12, 5'd11}));
    check("b2b rf_wdata", 128'(rf_wdata), 128'({32'hB2, 32'hB1}));
    repeat (6) cycle(1'b0, idle_b);

    // Random traffic with occasional resets against the queue model.
    for (int k = 0; k < 600; k++) begin
      rb = rand_bundle();
      reset = ($urandom_range(0, 59) == 0);
      cycle(!reset && ($urandom_range(0, 9) < 7), rb);
      reset = 1'b0;
    end
    repeat (6) cycle(1'b0, idle_b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
